// File: rtl/adc_readout_scheduler_if.sv
// Sample-capture inputs, trigger controls and framed serial outputs of the readout scheduler.
interface adc_readout_scheduler_if #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned NCH        = 3,
  parameter int unsigned INTERVAL_W = 16
);
  logic [NCH-1:0]       sample_valid;
  logic [NCH*WIDTH-1:0] sample_data;
  logic [NCH-1:0]       ch_enable;
  logic                 trig_ext;
  logic                 auto_mode;
  logic [INTERVAL_W-1:0] interval;
  logic                 clr_ovr;
  logic                 serial_out;
  logic                 frame_valid;
  logic                 busy;
  logic                 frame_done;
  logic                 overrun;

  modport master (
    output sample_valid, sample_data, ch_enable, trig_ext, auto_mode, interval, clr_ovr,
    input  serial_out, frame_valid, busy, frame_done, overrun
  );

  modport slave (
    input  sample_valid, sample_data, ch_enable, trig_ext, auto_mode, interval, clr_ovr,
    output serial_out, frame_valid, busy, frame_done, overrun
  );
endinterface

// File: rtl/adc_readout_scheduler.sv
// Captures per-channel decimated samples and serialises enabled channels as framed packets:
// 1010 sync, then per channel {id[1:0], fresh, sample MSB first}, then one idle DONE cycle.
module adc_readout_scheduler #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned NCH        = 3,
  parameter int unsigned INTERVAL_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  adc_readout_scheduler_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StSync, StHdr, StData, StDone} state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [1:0]                 ch_q, ch_d;
  logic [NCH-1:0]             en_q, en_d;
  logic [NCH-1:0][WIDTH-1:0]  hold_q, hold_d, snap_q, snap_d;
  logic [NCH-1:0]             fresh_q, fresh_d, snap_fresh_q, snap_fresh_d;
  logic                       trig_prev_q;
  logic [INTERVAL_W-1:0]      tmr_q, tmr_d;
  logic                       ovr_q, ovr_d;
  logic                       serial_q, serial_d, fv_q, fv_d, busy_q, busy_d, done_q, done_d;

  logic                       tmr_fire, trig, accept, drop;
  logic [1:0]                 first_ch, next_ch;
  logic                       next_found;
  logic [WIDTH-1:0]           word;
  logic [CntW-1:0]            bit_idx;

  // Trigger sources: rising edge of trig_ext or interval timer expiry, merged into one trigger.
  always_comb begin
    tmr_d    = '0;
    tmr_fire = 1'b0;
    if (bus_io.auto_mode && (bus_io.interval != '0)) begin
      if (tmr_q == bus_io.interval - INTERVAL_W'(1)) begin
        tmr_fire = 1'b1;
      end else begin
        tmr_d = tmr_q + INTERVAL_W'(1);
      end
    end
    trig   = (bus_io.trig_ext & ~trig_prev_q) | tmr_fire;
    accept = trig && (state_q == StIdle) && (bus_io.ch_enable != '0);
    // DONE counts as not-idle, so a trigger there is dropped too.
    drop   = trig && (state_q != StIdle);
    ovr_d  = ovr_q;
    if (bus_io.clr_ovr) ovr_d = 1'b0;
    if (drop) ovr_d = 1'b1;
  end

  // Sample capture runs in every state; on acceptance the snapshot takes forwarded data.
  always_comb begin
    snap_d       = snap_q;
    snap_fresh_d = snap_fresh_q;
    for (int i = 0; i < int'(NCH); i++) begin
      hold_d[i]  = bus_io.sample_valid[i] ? bus_io.sample_data[i*WIDTH +: WIDTH] : hold_q[i];
      fresh_d[i] = bus_io.sample_valid[i] | fresh_q[i];
      if (accept) begin
        snap_d[i]       = hold_d[i];
        snap_fresh_d[i] = fresh_d[i];
        fresh_d[i]      = 1'b0;
      end
    end
  end

  // Lowest enabled channel overall, and lowest enabled channel above the current one.
  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (en_q[i]) first_ch = 2'(i);
      if (en_q[i] && (i > int'(ch_q))) begin
        next_ch    = 2'(i);
        next_found = 1'b1;
      end
    end
  end

  // Frame sequencing: state, bit counter within the field, current channel.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    en_d    = en_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSync;
          cnt_d   = '0;
          en_d    = bus_io.ch_enable;
        end
      end
      StSync: begin
        if (cnt_q == CntW'(3)) begin
          state_d = StHdr;
          cnt_d   = '0;
          ch_d    = first_ch;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHdr: begin
        if (cnt_q == CntW'(2)) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntW'(WIDTH - 1)) begin
          cnt_d = '0;
          if (next_found) begin
            state_d = StHdr;
            ch_d    = next_ch;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the cycle they describe.
  always_comb begin
    serial_d = 1'b0;
    fv_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    word     = snap_q[ch_d];
    bit_idx  = CntW'(WIDTH - 1) - cnt_d;
    unique case (state_d)
      StSync: begin
        serial_d = ~cnt_d[0];
        fv_d     = (cnt_d == '0);
        busy_d   = 1'b1;
      end
      StHdr: begin
        busy_d = 1'b1;
        if (cnt_d == CntW'(0))      serial_d = ch_d[1];
        else if (cnt_d == CntW'(1)) serial_d = ch_d[0];
        else                        serial_d = snap_fresh_q[ch_d];
      end
      StData: begin
        busy_d   = 1'b1;
        serial_d = word[bit_idx];
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  // All state and registered outputs; synchronous reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ch_q         <= '0;
      en_q         <= '0;
      hold_q       <= '0;
      snap_q       <= '0;
      fresh_q      <= '0;
      snap_fresh_q <= '0;
      trig_prev_q  <= 1'b0;
      tmr_q        <= '0;
      ovr_q        <= 1'b0;
      serial_q     <= 1'b0;
      fv_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      en_q         <= en_d;
      hold_q       <= hold_d;
      snap_q       <= snap_d;
      fresh_q      <= fresh_d;
      snap_fresh_q <= snap_fresh_d;
      trig_prev_q  <= bus_io.trig_ext;
      tmr_q        <= tmr_d;
      ovr_q        <= ovr_d;
      serial_q     <= serial_d;
      fv_q         <= fv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus_io.serial_out  = serial_q;
  assign bus_io.frame_valid = fv_q;
  assign bus_io.busy        = busy_q;
  assign bus_io.frame_done  = done_q;
  assign bus_io.overrun     = ovr_q;

endmodule

// File: tb/tb_adc_readout_scheduler.sv
// Directed bench for adc_readout_scheduler: table of framed packets plus hand-written
// sequences for ignored triggers, auto-mode overrun and mid-frame reset.
module tb_adc_readout_scheduler;
  localparam int W  = 13;
  localparam int N  = 3;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_n    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  adc_readout_scheduler_if #(.WIDTH(W), .NCH(N), .INTERVAL_W(IW)) bus ();

  adc_readout_scheduler #(.WIDTH(W), .NCH(N), .INTERVAL_W(IW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic [N-1:0] pre_valid;
    logic [W-1:0] pre_a;
    logic [W-1:0] pre_b;
    logic [W-1:0] pre_c;
    logic [N-1:0] en;
    logic         fwd0;
    logic [W-1:0] fwd_data;
    int           len;
    logic [63:0]  bits;
  } vec_t;

  vec_t vecs[5];
  vec_t rvec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Loads optional samples, triggers, then checks every frame bit, DONE and the idle after it.
  task automatic run_frame(input string tag, input vec_t v);
    logic expb;
    if (v.pre_valid != '0) begin
      bus.sample_data  = {v.pre_c, v.pre_b, v.pre_a};
      bus.sample_valid = v.pre_valid;
      cyc();
      bus.sample_valid = '0;
    end
    bus.ch_enable = v.en;
    bus.trig_ext  = 1'b1;
    if (v.fwd0) begin
      bus.sample_valid       = 3'b001;
      bus.sample_data[W-1:0] = v.fwd_data;
    end
    cyc();
    bus.sample_valid = '0;
    for (int k = 0; k < v.len; k++) begin
      @(negedge clk);
      expb = v.bits[v.len-1-k];
      check($sformatf("%s bit%0d {ser,fv,busy,done}", tag, k),
            {bus.serial_out, bus.frame_valid, bus.busy, bus.frame_done},
            {expb, (k == 0), 1'b1, 1'b0});
      cyc();
    end
    @(negedge clk);
    check({tag, " done cycle {ser,fv,busy,done}"},
          {bus.serial_out, bus.frame_valid, bus.busy, bus.frame_done}, 4'b0001);
    cyc();
    @(negedge clk);
    check({tag, " after done {ser,busy,done,ovr}"},
          {bus.serial_out, bus.busy, bus.frame_done, bus.overrun}, 4'b0000);
    bus.trig_ext = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.frame_done) begin
        ok = 1;
        break;
      end
    end
    check({tag, " idle reached"}, 64'(ok), 64'd1);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv_t[3];
    int nfv;
    int ovr_t;

    vecs[0] = '{pre_valid: 3'b111, pre_a: 13'h0155, pre_b: 13'h1AAA, pre_c: 13'h0001,
                en: 3'b111, fwd0: 1'b0, fwd_data: '0, len: 52,
                bits: 64'({4'b1010, 2'b00, 1'b1, 13'h0155, 2'b01, 1'b1, 13'h1AAA,
                           2'b10, 1'b1, 13'h0001})};
    vecs[1] = '{pre_valid: 3'b000, pre_a: '0, pre_b: '0, pre_c: '0,
                en: 3'b010, fwd0: 1'b0, fwd_data: '0, len: 20,
                bits: 64'({4'b1010, 2'b01, 1'b0, 13'h1AAA})};
    vecs[2] = '{pre_valid: 3'b000, pre_a: '0, pre_b: '0, pre_c: '0,
                en: 3'b001, fwd0: 1'b1, fwd_data: 13'h0ABC, len: 20,
                bits: 64'({4'b1010, 2'b00, 1'b1, 13'h0ABC})};
    vecs[3] = '{pre_valid: 3'b000, pre_a: '0, pre_b: '0, pre_c: '0,
                en: 3'b001, fwd0: 1'b0, fwd_data: '0, len: 20,
                bits: 64'({4'b1010, 2'b00, 1'b0, 13'h0ABC})};
    vecs[4] = '{pre_valid: 3'b100, pre_a: '0, pre_b: '0, pre_c: 13'h1FFF,
                en: 3'b101, fwd0: 1'b0, fwd_data: '0, len: 36,
                bits: 64'({4'b1010, 2'b00, 1'b0, 13'h0ABC, 2'b10, 1'b1, 13'h1FFF})};

    rst              = 1'b1;
    bus.sample_valid = '0;
    bus.sample_data  = '0;
    bus.ch_enable    = '0;
    bus.trig_ext     = 1'b0;
    bus.auto_mode    = 1'b0;
    bus.interval     = '0;
    bus.clr_ovr      = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check("reset outputs {ser,fv,busy,done,ovr}",
          {bus.serial_out, bus.frame_valid, bus.busy, bus.frame_done, bus.overrun}, 5'b0);
    cyc();
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Trigger with no channel enabled: nothing happens.
    bus.ch_enable = '0;
    bus.trig_ext  = 1'b1;
    cyc();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check($sformatf("en0 quiet cyc%0d {ser,fv,busy,done,ovr}", i),
            {bus.serial_out, bus.frame_valid, bus.busy, bus.frame_done, bus.overrun}, 5'b0);
      cyc();
    end
    bus.trig_ext = 1'b0;
    cyc();

    // Auto mode, interval 60: frames every 60 cycles, no overrun.
    bus.ch_enable = 3'b111;
    bus.interval  = 16'd60;
    bus.auto_mode = 1'b1;
    nfv = 0;
    for (int i = 0; i < 250 && nfv < 3; i++) begin
      @(negedge clk);
      if (bus.frame_valid) begin
        fv_t[nfv] = cyc_n;
        nfv++;
      end
      cyc();
    end
    check("auto60 frames seen", 64'(nfv), 64'd3);
    if (nfv == 3) begin
      check("auto60 spacing 1", 64'(fv_t[1] - fv_t[0]), 64'd60);
      check("auto60 spacing 2", 64'(fv_t[2] - fv_t[1]), 64'd60);
    end
    check("auto60 overrun", 64'(bus.overrun), 64'd0);
    bus.auto_mode = 1'b0;
    wait_idle("auto60");

    // Auto mode, interval 40: second expiry lands at frame bit 40 and is dropped.
    bus.interval  = 16'd40;
    bus.auto_mode = 1'b1;
    nfv   = 0;
    ovr_t = -1;
    for (int i = 0; i < 200 && nfv < 2; i++) begin
      @(negedge clk);
      if (bus.frame_valid) begin
        fv_t[nfv] = cyc_n;
        nfv++;
      end
      if (bus.overrun && ovr_t < 0) ovr_t = cyc_n;
      cyc();
    end
    bus.auto_mode = 1'b0;
    check("auto40 frames seen", 64'(nfv), 64'd2);
    if (nfv == 2) begin
      check("auto40 accepted spacing", 64'(fv_t[1] - fv_t[0]), 64'd80);
      check("auto40 overrun cycle offset", 64'(ovr_t - fv_t[0]), 64'd40);
    end
    @(negedge clk);
    check("auto40 overrun sticky", 64'(bus.overrun), 64'd1);
    cyc();
    bus.clr_ovr = 1'b1;
    cyc();
    bus.clr_ovr = 1'b0;
    @(negedge clk);
    check("clr_ovr clears", 64'(bus.overrun), 64'd0);
    cyc();
    wait_idle("auto40");

    // Mid-frame reset after forcing an overrun with a second trig_ext edge.
    bus.sample_data  = {13'h0777, 13'h0666, 13'h0555};
    bus.sample_valid = 3'b111;
    cyc();
    bus.sample_valid = '0;
    bus.ch_enable    = 3'b111;
    bus.trig_ext     = 1'b1;
    cyc();
    bus.trig_ext = 1'b0;
    cyc();
    cyc();
    bus.trig_ext = 1'b1;
    cyc();
    @(negedge clk);
    check("busy drop sets overrun", 64'(bus.overrun), 64'd1);
    repeat (16) cyc();
    rst          = 1'b1;
    bus.trig_ext = 1'b0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("mid-frame reset {ser,fv,busy,done,ovr}",
          {bus.serial_out, bus.frame_valid, bus.busy, bus.frame_done, bus.overrun}, 5'b0);
    cyc();
    cyc();
    rvec = '{pre_valid: 3'b000, pre_a: '0, pre_b: '0, pre_c: '0,
             en: 3'b111, fwd0: 1'b0, fwd_data: '0, len: 52,
             bits: 64'({4'b1010, 2'b00, 1'b0, 13'h0000, 2'b01, 1'b0, 13'h0000,
                        2'b10, 1'b0, 13'h0000})};
    run_frame("post-reset", rvec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
